weight_feeder: RTL and testbench

- Transmit side of the PE weight shift chain.
- Accepts a burst of N_PE signed weights over a valid/ready stream from the weight buffer and drives the chain's shared wen and first-stage win.
- Each accepted beat produces exactly one shift of the chain, so after a load the first weight sent sits in the farthest PE and the last weight sent sits in the first PE.
- Sits between the weight buffer and the PE row/column; one instance per chain.

---
 rtl/tpu_pkg.sv | 25 ++
 rtl/weight_feeder.sv | 69 ++++++
 tb/tb_weight_feeder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: weight width default,
// weight feeder state encoding and a clog2 helper.
package tpu_pkg;

  localparam int W_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } feed_state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/weight_feeder.sv
// Weight feeder: streams N_PE weights into a PE shift chain.
// Ports: clk, reset_n, start, s_valid/s_data/s_ready, wen, win, busy, done.
module weight_feeder
  import tpu_pkg::*;
#(
  parameter int N_PE    = 4,
  parameter int W_WIDTH = W_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               s_valid,
  input  logic [W_WIDTH-1:0] s_data,
  output logic               s_ready,
  output logic               wen,
  output logic [W_WIDTH-1:0] win,
  output logic               busy,
  output logic               done
);

  localparam int CW = clog2(N_PE + 1);
  localparam logic [CW-1:0] LAST = CW'(N_PE - 1);

  feed_state_e state;
  feed_state_e state_n;
  logic [CW-1:0] cnt;
  logic          fire;

  assign s_ready = (state == ST_LOAD);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign fire    = s_valid & s_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start) state_n = ST_LOAD;
      ST_LOAD: if (fire && cnt == LAST) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // win holds across stalls so the chain input stays stable
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      wen <= 1'b0;
      win <= '0;
    end else begin
      wen <= fire;
      if (fire) begin
        win <= s_data;
        cnt <= cnt + CW'(1);
      end else if (state == ST_IDLE && start) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_weight_feeder.sv
// Self-checking bench for weight_feeder with a 4-PE chain behind it.
// Table vectors, hand sequences and randomized loads vs a beat-level model.
module tb_weight_feeder;

  localparam int N = 4;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       wen;
  logic [7:0] win;
  logic       busy;
  logic       done;

  weight_feeder #(.N_PE(N), .W_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wen(wen), .win(win), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE chain: pe[0] is PE1, pe[3] is PE4
  logic [7:0] pe [N];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) pe[i] <= 8'h00;
    end else if (wen) begin
      pe[0] <= win;
      for (int i = 1; i < N; i++) pe[i] <= pe[i-1];
    end
  end

  typedef struct packed {
    logic [31:0]      vmask;
    logic [3:0][7:0]  d;
    int               restart_at;
    logic [3:0][7:0]  exp_pe;
    int               exp_done;
  } vec_t;

  int n_cmp;
  int n_bad;
  logic [7:0] m_win;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] m,
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input logic [7:0] e,
    input int rs,
    input logic [7:0] p1, input logic [7:0] p2,
    input logic [7:0] p3, input logic [7:0] p4,
    input int dn);
    vec_t v;
    v.vmask = m;
    v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = e;
    v.restart_at = rs;
    v.exp_pe[0] = p1; v.exp_pe[1] = p2;
    v.exp_pe[2] = p3; v.exp_pe[3] = p4;
    v.exp_done = dn;
    return v;
  endfunction

  // One full load: cycle 0 is the start edge, cycle c>=1 offers
  // vmask[c-1]. The first N offered beats are accepted.
  task automatic run_load(input string nm, input vec_t v);
    int beats;
    int done_c;
    bit acc;
    bit vc;
    start = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, ".start_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, ".start_rdy"}, {31'd0, s_ready}, 32'd1);
    chk({nm, ".start_wen"}, {31'd0, wen}, 32'd0);
    beats = 0;
    done_c = -1;
    for (int c = 1; c < 32; c++) begin
      vc = v.vmask[c-1];
      s_valid = vc;
      s_data = vc ? v.d[beats] : 8'h5A;
      start = (c == v.restart_at);
      @(posedge clk); #1;
      start = 1'b0;
      acc = vc && beats < N;
      if (acc) begin
        m_win = v.d[beats];
        beats++;
      end
      chk({nm, ".wen"}, {31'd0, wen}, {31'd0, acc});
      chk({nm, ".win"}, {24'd0, win}, {24'd0, m_win});
      chk({nm, ".done"}, {31'd0, done},
          {31'd0, (acc && beats == N)});
      if (beats == N) begin
        done_c = c;
        break;
      end
    end
    if (done_c < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: got %0d beats expected %0d",
               nm, beats, N);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, ".end_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, ".end_rdy"}, {31'd0, s_ready}, 32'd0);
    chk({nm, ".end_wen"}, {31'd0, wen}, 32'd0);
    chk({nm, ".end_done"}, {31'd0, done}, 32'd0);
    chk({nm, ".done_cycle"}, done_c, v.exp_done);
    for (int k = 0; k < N; k++)
      chk({nm, ".pe"}, {24'd0, pe[k]}, {24'd0, v.exp_pe[k]});
  endtask

  vec_t tbl [5];
  vec_t rv;
  int   setb;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_win = 8'h00;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;

    tbl[0] = mk(32'h0000_000F, 8'd1, 8'd2, 8'd3, 8'd4, 0,
                8'd4, 8'd3, 8'd2, 8'd1, 4);
    tbl[1] = mk(32'h0000_0063, 8'd1, 8'd2, 8'd3, 8'd4, 0,
                8'd4, 8'd3, 8'd2, 8'd1, 7);
    tbl[2] = mk(32'h0000_000F, 8'h80, 8'h7F, 8'hFF, 8'h00, 0,
                8'h00, 8'hFF, 8'h7F, 8'h80, 4);
    tbl[3] = mk(32'h0000_000F, 8'h10, 8'h20, 8'h30, 8'h40, 2,
                8'h40, 8'h30, 8'h20, 8'h10, 4);
    tbl[4] = mk(32'h0000_000F, 8'd5, 8'd6, 8'd7, 8'd8, 0,
                8'd8, 8'd7, 8'd6, 8'd5, 4);

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wen", {31'd0, wen}, 32'd0);
    chk("rst.win", {24'd0, win}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.rdy", {31'd0, s_ready}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      run_load($sformatf("vec%0d", i), tbl[i]);

    // reset after beat 2 abandons the load
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h11;
    @(posedge clk); #1;
    s_data = 8'h22;
    @(posedge clk); #1;
    chk("mid.wen2", {31'd0, wen}, 32'd1);
    chk("mid.win2", {24'd0, win}, 32'h22);
    reset_n = 1'b0;
    s_data = 8'h33;
    @(posedge clk); #1;
    reset_n = 1'b1;
    s_valid = 1'b0;
    m_win = 8'h00;
    chk("mid.wen", {31'd0, wen}, 32'd0);
    chk("mid.busy", {31'd0, busy}, 32'd0);
    chk("mid.rdy", {31'd0, s_ready}, 32'd0);
    chk("mid.done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid.nodone", {31'd0, done}, 32'd0);
    end
    run_load("fresh", tbl[4]);

    // valid offered while idle is never consumed
    s_valid = 1'b1;
    s_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle.rdy", {31'd0, s_ready}, 32'd0);
      chk("idle.wen", {31'd0, wen}, 32'd0);
      chk("idle.pe1", {24'd0, pe[0]}, 32'd8);
    end
    s_valid = 1'b0;
    run_load("after_idle", tbl[0]);

    for (int r = 0; r < 10; r++) begin
      rv.vmask = $urandom;
      rv.vmask[27:24] = 4'hF;
      for (int k = 0; k < N; k++) rv.d[k] = 8'($urandom);
      for (int k = 0; k < N; k++) rv.exp_pe[k] = rv.d[N-1-k];
      rv.restart_at = (r % 3 == 0) ? 3 : 0;
      setb = 0;
      rv.exp_done = -1;
      for (int c = 1; c < 32; c++) begin
        if (rv.vmask[c-1] && setb < N) begin
          setb++;
          if (setb == N) rv.exp_done = c;
        end
      end
      run_load($sformatf("rnd%0d", r), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
